// File: rtl/a1339_spi_responder.sv
// a1339_spi_responder
// Emulates an A1339 angle sensor on an SPI mode 3 bus (CPOL=1, CPHA=1,
// MSB first, 20-bit frames). The master sends a 16-bit command plus a CRC4.
// The responder returns {status, angle} plus a CRC4 in the same frame.
// All SPI pins are oversampled in the system clock domain.
//
// Ports
//   clock, reset_n      system clock, asynchronous active-low reset
//   sck_i, ss_n_i       SPI clock (idles high) and slave select (active low)
//   mosi_i / miso_o     serial data in / out (miso_o is 0 when not selected)
//   miso_oe_o           high while a frame is being served (external tri-state)
//   angle_i, status_i   response contents, snapshotted at frame start
//   crc_corrupt_i       inverts response CRC bit 0 for the frame it starts
//   cmd_o               last command received with a good CRC
//   cmd_valid_o         pulse: good 20-bit frame
//   crc_err_o           pulse: 20-bit frame with a CRC mismatch
//   frame_err_o         pulse: frame ended with a bit count other than 20
//   frame_count_o       number of completed 20-bit frames (wraps)

module a1339_spi_responder #(
    parameter int         SYNC_STAGES    = 2,
    parameter int         FRAME_BITS     = 20,
    parameter logic [3:0] STATUS_DEFAULT = 4'h0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        sck_i,
    input  logic        ss_n_i,
    input  logic        mosi_i,
    output logic        miso_o,
    output logic        miso_oe_o,
    input  logic [11:0] angle_i,
    input  logic [3:0]  status_i,
    input  logic        crc_corrupt_i,
    output logic [15:0] cmd_o,
    output logic        cmd_valid_o,
    output logic        crc_err_o,
    output logic        frame_err_o,
    output logic [15:0] frame_count_o
);

    localparam logic [4:0] BitsFull    = 5'(FRAME_BITS);
    localparam logic [4:0] BitsSat     = 5'(FRAME_BITS + 1);
    localparam logic [4:0] PayloadBits = 5'(FRAME_BITS - 4);

    typedef enum logic [1:0] {
        WAIT_DESELECT,
        IDLE,
        ACTIVE,
        EVAL
    } state_t;

    // One serial step of CRC4 x^4+x+1, MSB first.
    function automatic logic [3:0] crc4Step(input logic [3:0] c, input logic d);
        logic inv;
        inv = d ^ c[3];
        return {c[2], c[1], c[0] ^ inv, inv};
    endfunction

    // CRC4 of a full 16-bit word, unrolled so the response CRC is ready
    // in the same cycle the frame is loaded.
    function automatic logic [3:0] crc4Word(input logic [15:0] w);
        logic [3:0] c;
        c = 4'hF;
        for (int i = 15; i >= 0; i--) begin
            c = crc4Step(c, w[i]);
        end
        return c;
    endfunction

    logic [SYNC_STAGES-1:0] sckSync_q;
    logic [SYNC_STAGES-1:0] ssSync_q;
    logic [SYNC_STAGES-1:0] mosiSync_q;
    logic                   sckPrev_q;
    logic                   ssPrev_q;

    logic sckS, ssS, mosiS;
    logic sckRise, sckFall, ssRise, ssFall;

    state_t                 state_q, state_d;
    logic [FRAME_BITS-1:0]  txShift_q, txShift_d;
    logic [FRAME_BITS-1:0]  rxShift_q, rxShift_d;
    logic [3:0]             rxCrc_q, rxCrc_d;
    logic [4:0]             bitCount_q, bitCount_d;
    logic                   miso_q, miso_d;
    logic                   misoOe_q, misoOe_d;
    logic [15:0]            cmd_q, cmd_d;
    logic                   cmdValid_q, cmdValid_d;
    logic                   crcErr_q, crcErr_d;
    logic                   frameErr_q, frameErr_d;
    logic [15:0]            frameCount_q, frameCount_d;
    logic [15:0]            resp;

    // The select chain resets to "selected" so that a frame already running
    // when reset is released never produces a false select edge; the FSM
    // waits for a genuine deselect first.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sckSync_q  <= '1;
            ssSync_q   <= '0;
            mosiSync_q <= '0;
            sckPrev_q  <= 1'b1;
            ssPrev_q   <= 1'b0;
        end else begin
            sckSync_q  <= {sckSync_q[SYNC_STAGES-2:0], sck_i};
            ssSync_q   <= {ssSync_q[SYNC_STAGES-2:0], ss_n_i};
            mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], mosi_i};
            sckPrev_q  <= sckS;
            ssPrev_q   <= ssS;
        end
    end

    assign sckS    = sckSync_q[SYNC_STAGES-1];
    assign ssS     = ssSync_q[SYNC_STAGES-1];
    assign mosiS   = mosiSync_q[SYNC_STAGES-1];
    assign sckRise = sckS & ~sckPrev_q;
    assign sckFall = ~sckS & sckPrev_q;
    assign ssRise  = ssS & ~ssPrev_q;
    assign ssFall  = ~ssS & ssPrev_q;

    assign resp = {status_i | STATUS_DEFAULT, angle_i};

    // Next-state and datapath. Select edges take priority over SCK edges in
    // the same cycle; SCK edges are only honoured while ACTIVE.
    always_comb begin
        state_d      = state_q;
        txShift_d    = txShift_q;
        rxShift_d    = rxShift_q;
        rxCrc_d      = rxCrc_q;
        bitCount_d   = bitCount_q;
        miso_d       = miso_q;
        misoOe_d     = misoOe_q;
        cmd_d        = cmd_q;
        cmdValid_d   = 1'b0;
        crcErr_d     = 1'b0;
        frameErr_d   = 1'b0;
        frameCount_d = frameCount_q;

        case (state_q)
            WAIT_DESELECT: begin
                if (ssS) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (ssFall) begin
                    txShift_d  = {resp, crc4Word(resp) ^ {3'b000, crc_corrupt_i}};
                    rxShift_d  = '0;
                    rxCrc_d    = 4'hF;
                    bitCount_d = '0;
                    miso_d     = 1'b0;
                    misoOe_d   = 1'b1;
                    state_d    = ACTIVE;
                end
            end
            ACTIVE: begin
                if (ssRise) begin
                    miso_d   = 1'b0;
                    misoOe_d = 1'b0;
                    state_d  = EVAL;
                end else if (sckFall) begin
                    miso_d    = txShift_q[FRAME_BITS-1];
                    txShift_d = {txShift_q[FRAME_BITS-2:0], 1'b0};
                end else if (sckRise) begin
                    rxShift_d = {rxShift_q[FRAME_BITS-2:0], mosiS};
                    if (bitCount_q < PayloadBits) begin
                        rxCrc_d = crc4Step(rxCrc_q, mosiS);
                    end
                    if (bitCount_q != BitsSat) begin
                        bitCount_d = bitCount_q + 5'd1;
                    end
                end
            end
            EVAL: begin
                state_d = IDLE;
                if (bitCount_q == BitsFull) begin
                    frameCount_d = frameCount_q + 16'd1;
                    if (rxShift_q[3:0] == rxCrc_q) begin
                        cmd_d      = rxShift_q[FRAME_BITS-1:4];
                        cmdValid_d = 1'b1;
                    end else begin
                        crcErr_d = 1'b1;
                    end
                end else begin
                    frameErr_d = 1'b1;
                end
            end
            default: state_d = WAIT_DESELECT;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= WAIT_DESELECT;
            txShift_q    <= '0;
            rxShift_q    <= '0;
            rxCrc_q      <= '0;
            bitCount_q   <= '0;
            miso_q       <= 1'b0;
            misoOe_q     <= 1'b0;
            cmd_q        <= '0;
            cmdValid_q   <= 1'b0;
            crcErr_q     <= 1'b0;
            frameErr_q   <= 1'b0;
            frameCount_q <= '0;
        end else begin
            state_q      <= state_d;
            txShift_q    <= txShift_d;
            rxShift_q    <= rxShift_d;
            rxCrc_q      <= rxCrc_d;
            bitCount_q   <= bitCount_d;
            miso_q       <= miso_d;
            misoOe_q     <= misoOe_d;
            cmd_q        <= cmd_d;
            cmdValid_q   <= cmdValid_d;
            crcErr_q     <= crcErr_d;
            frameErr_q   <= frameErr_d;
            frameCount_q <= frameCount_d;
        end
    end

    assign miso_o        = miso_q;
    assign miso_oe_o     = misoOe_q;
    assign cmd_o         = cmd_q;
    assign cmd_valid_o   = cmdValid_q;
    assign crc_err_o     = crcErr_q;
    assign frame_err_o   = frameErr_q;
    assign frame_count_o = frameCount_q;

endmodule

// File: tb/tb_a1339_spi_responder.sv
// tb_a1339_spi_responder
// Drives SPI mode 3 frames into a1339_spi_responder acting as the master.
// Expected end-of-frame events (kind, cmd_o, frame_count_o) are queued when a
// frame is sent and compared when the DUT raises a pulse, including the
// pulse latency measured from the ss_n_i rising edge.

module tb_a1339_spi_responder;

    localparam time HALF = 100ns;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        sck_i;
    logic        ss_n_i;
    logic        mosi_i;
    logic        miso_o;
    logic        miso_oe_o;
    logic [11:0] angle_i;
    logic [3:0]  status_i;
    logic        crc_corrupt_i;
    logic [15:0] cmd_o;
    logic        cmd_valid_o;
    logic        crc_err_o;
    logic        frame_err_o;
    logic [15:0] frame_count_o;

    typedef struct {
        int          kind;
        logic [15:0] cmd;
        logic [15:0] count;
    } exp_t;

    exp_t        expQ[$];
    int          checks = 0;
    int          errors = 0;
    int          cycleCnt = 0;
    int          riseCycle = 0;
    logic [15:0] expCmd = 16'h0000;
    logic [15:0] expCount = 16'h0000;

    always #5ns clock = ~clock;

    a1339_spi_responder #(
        .SYNC_STAGES(2),
        .FRAME_BITS(20),
        .STATUS_DEFAULT(4'h0)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .sck_i(sck_i),
        .ss_n_i(ss_n_i),
        .mosi_i(mosi_i),
        .miso_o(miso_o),
        .miso_oe_o(miso_oe_o),
        .angle_i(angle_i),
        .status_i(status_i),
        .crc_corrupt_i(crc_corrupt_i),
        .cmd_o(cmd_o),
        .cmd_valid_o(cmd_valid_o),
        .crc_err_o(crc_err_o),
        .frame_err_o(frame_err_o),
        .frame_count_o(frame_count_o)
    );

    // Reference CRC4 (x^4+x+1, init F, MSB first) in shift-and-xor form.
    function automatic logic [3:0] crcModel(input logic [15:0] w);
        logic [3:0] c;
        c = 4'hF;
        for (int i = 15; i >= 0; i--) begin
            if (w[i] ^ c[3]) c = {c[2:0], 1'b0} ^ 4'b0011;
            else             c = {c[2:0], 1'b0};
        end
        return c;
    endfunction

    function automatic void pushExp(input int kind, input logic [15:0] word);
        exp_t e;
        if (kind == 0) expCmd = word;
        if (kind != 2) expCount = expCount + 16'd1;
        e.kind  = kind;
        e.cmd   = expCmd;
        e.count = expCount;
        expQ.push_back(e);
    endfunction

    initial begin
        forever begin
            @(posedge clock);
            cycleCnt++;
        end
    end

    // Scoreboard monitor: every pulse must match the oldest queued event.
    initial begin
        int   obsKind;
        exp_t e;
        forever begin
            @(negedge clock);
            if (cmd_valid_o || crc_err_o || frame_err_o) begin
                obsKind = 3;
                if ( cmd_valid_o && !crc_err_o && !frame_err_o) obsKind = 0;
                if (!cmd_valid_o &&  crc_err_o && !frame_err_o) obsKind = 1;
                if (!cmd_valid_o && !crc_err_o &&  frame_err_o) obsKind = 2;
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_pulse kind=%0d cmd=%h count=%0d", obsKind, cmd_o, frame_count_o);
                end else begin
                    e = expQ.pop_front();
                    if (obsKind !== e.kind || cmd_o !== e.cmd || frame_count_o !== e.count
                        || (cycleCnt - riseCycle) != 4) begin
                        errors++;
                        $display("[TB] FAIL frame_event got kind=%0d cmd=%h count=%0d lat=%0d want kind=%0d cmd=%h count=%0d lat=4",
                                 obsKind, cmd_o, frame_count_o, cycleCnt - riseCycle, e.kind, e.cmd, e.count);
                    end
                end
            end
        end
    end

    // One SPI frame of nBits clocks; MISO is captured on each rising edge.
    task automatic applyStimulus(input logic [19:0] word, input int nBits, output logic [19:0] misoWord);
        misoWord = '0;
        @(negedge clock);
        ss_n_i = 1'b0;
        #(2 * HALF);
        for (int i = 0; i < nBits; i++) begin
            sck_i  = 1'b0;
            mosi_i = (i < 20) ? word[19 - i] : 1'b0;
            #HALF;
            sck_i = 1'b1;
            if (i < 20) misoWord[19 - i] = miso_o;
            #HALF;
        end
        #(2 * HALF);
        @(negedge clock);
        ss_n_i    = 1'b1;
        riseCycle = cycleCnt;
        #(4 * HALF);
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 50 && expQ.size() != 0; i++) @(negedge clock);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_no_pulse pending=%0d want 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ss_n_i = 1'b1; sck_i = 1'b1; mosi_i = 1'b0;
        angle_i = '0; status_i = '0; crc_corrupt_i = 1'b0;
        #50ns;
        checks++; if (miso_o !== 1'b0)        begin errors++; $display("[TB] FAIL reset_miso got %b want 0", miso_o); end
        checks++; if (miso_oe_o !== 1'b0)     begin errors++; $display("[TB] FAIL reset_oe got %b want 0", miso_oe_o); end
        checks++; if (cmd_o !== 16'h0000)     begin errors++; $display("[TB] FAIL reset_cmd got %h want 0000", cmd_o); end
        checks++; if (frame_count_o !== 16'h0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", frame_count_o); end
        checks++;
        if ({cmd_valid_o, crc_err_o, frame_err_o} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_pulses got %b want 000", {cmd_valid_o, crc_err_o, frame_err_o});
        end
        @(negedge clock); reset_n = 1'b1;
        repeat (10) @(negedge clock);
    endtask

    task automatic test_good_frame();
        logic [19:0] r;
        pushExp(0, 16'h2000);
        applyStimulus(20'h20009, 20, r);
        waitDrain("good_frame");
    endtask

    task automatic test_bad_crc();
        logic [19:0] r;
        pushExp(1, 16'h0000);
        applyStimulus(20'h20008, 20, r);
        waitDrain("bad_crc");
    endtask

    task automatic test_response();
        logic [19:0] r;
        angle_i = 12'hABC; status_i = 4'h0; crc_corrupt_i = 1'b0;
        pushExp(0, 16'h1234);
        fork
            applyStimulus({16'h1234, crcModel(16'h1234)}, 20, r);
            begin
                #(10 * HALF);
                angle_i = 12'h123; status_i = 4'hF; crc_corrupt_i = 1'b1;
                checks++;
                if (miso_oe_o !== 1'b1) begin errors++; $display("[TB] FAIL active_oe got %b want 1", miso_oe_o); end
            end
        join
        checks++;
        if (r[19:4] !== 16'h0ABC) begin errors++; $display("[TB] FAIL resp_word got %h want 0abc", r[19:4]); end
        checks++;
        if (r[3:0] !== crcModel(16'h0ABC)) begin
            errors++; $display("[TB] FAIL resp_crc got %h want %h", r[3:0], crcModel(16'h0ABC));
        end
        checks++;
        if (miso_oe_o !== 1'b0 || miso_o !== 1'b0) begin
            errors++; $display("[TB] FAIL idle_miso got oe=%b miso=%b want 0 0", miso_oe_o, miso_o);
        end
        waitDrain("response");
    endtask

    task automatic test_status_corrupt();
        logic [19:0] r;
        logic [3:0]  want;
        angle_i = 12'hABC; status_i = 4'h5; crc_corrupt_i = 1'b1;
        want = crcModel(16'h5ABC) ^ 4'b0001;
        pushExp(0, 16'h2000);
        applyStimulus(20'h20009, 20, r);
        checks++;
        if (r[19:4] !== 16'h5ABC) begin errors++; $display("[TB] FAIL status_word got %h want 5abc", r[19:4]); end
        checks++;
        if (r[3:0] !== want) begin errors++; $display("[TB] FAIL corrupt_crc got %h want %h", r[3:0], want); end
        crc_corrupt_i = 1'b0; status_i = 4'h0;
        waitDrain("status_corrupt");
    endtask

    task automatic test_frame_errors();
        logic [19:0] r;
        pushExp(2, 16'h0000);
        applyStimulus(20'h20009, 12, r);
        waitDrain("short_frame");
        pushExp(2, 16'h0000);
        applyStimulus(20'h20009, 21, r);
        waitDrain("long_frame");
    endtask

    task automatic test_back_to_back();
        logic [19:0] r;
        pushExp(0, 16'hBEEF);
        applyStimulus({16'hBEEF, crcModel(16'hBEEF)}, 20, r);
        pushExp(1, 16'h0000);
        applyStimulus({16'h0001, ~crcModel(16'h0001)}, 20, r);
        pushExp(0, 16'h7FFF);
        applyStimulus({16'h7FFF, crcModel(16'h7FFF)}, 20, r);
        waitDrain("back_to_back");
    endtask

    task automatic test_reset_mid_frame();
        logic [19:0] r;
        @(negedge clock);
        ss_n_i = 1'b0;
        #(2 * HALF);
        for (int i = 0; i < 5; i++) begin
            sck_i = 1'b0; mosi_i = 1'b1; #HALF; sck_i = 1'b1; #HALF;
        end
        reset_n = 1'b0;
        #1ns;
        checks++;
        if (miso_oe_o !== 1'b0 || cmd_o !== 16'h0 || frame_count_o !== 16'h0) begin
            errors++; $display("[TB] FAIL midreset_outputs got oe=%b cmd=%h count=%0d want 0 0000 0", miso_oe_o, cmd_o, frame_count_o);
        end
        expCmd = 16'h0000; expCount = 16'h0000;
        #50ns;
        @(negedge clock); reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sck_i = 1'b0; mosi_i = i[0]; #HALF; sck_i = 1'b1; #HALF;
        end
        checks++;
        if (miso_oe_o !== 1'b0) begin errors++; $display("[TB] FAIL midreset_oe got %b want 0", miso_oe_o); end
        @(negedge clock); ss_n_i = 1'b1;
        repeat (20) @(negedge clock);
        checks++;
        if (miso_oe_o !== 1'b0) begin errors++; $display("[TB] FAIL deselect_oe got %b want 0", miso_oe_o); end
        pushExp(0, 16'h2000);
        applyStimulus(20'h20009, 20, r);
        waitDrain("after_reset");
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_good_frame();
        test_bad_crc();
        test_response();
        test_status_corrupt();
        test_frame_errors();
        test_back_to_back();
        test_reset_mid_frame();
        repeat (20) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

endmodule
